// File: rtl/aximm_patgen_seq_if.sv
// Sequencer-to-generator link: burst launch controls toward the pattern generator,
// checker-FIFO backpressure coming back.
interface aximm_patgen_seq_if #(
  parameter int SW = 40
);
  logic          gen_ena;
  logic [SW-1:0] gen_seed;
  logic [7:0]    gen_patcnt;
  logic          gen_wr_en;
  logic          gen_fifo_full;

  modport master (
    output gen_ena, gen_seed, gen_patcnt, gen_wr_en,
    input  gen_fifo_full
  );

  modport slave (
    input  gen_ena, gen_seed, gen_patcnt, gen_wr_en,
    output gen_fifo_full
  );
endinterface

// File: rtl/aximm_patgen_seq.sv
// Run sequencer for the AXI-MM incrementing pattern generator: launches seeded bursts,
// paces them around checker-FIFO backpressure, inserts idle gaps and keeps run statistics.
module aximm_patgen_seq #(
  parameter  int LEADER_MODE = 1,
  localparam int SW          = LEADER_MODE * 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SW-1:0]        cfg_seed,
  input  logic [7:0]           cfg_burst_len,
  input  logic [7:0]           cfg_num_bursts,
  input  logic [3:0]           cfg_gap,
  aximm_patgen_seq_if.master   gen,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [7:0]           burst_idx,
  output logic [15:0]          word_cnt,
  output logic [15:0]          stall_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, BURST, GAP, DONE} state_t;

  state_t     state;
  logic [7:0] num_bursts;
  logic [3:0] gap;
  logic [3:0] gap_cnt;
  logic [7:0] beat;
  logic       empty_hold;
  logic       last_word;

  // gen_patcnt doubles as the shadow copy of the burst length for the whole run.
  assign last_word = ~gen.gen_fifo_full & (beat == gen.gen_patcnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      num_bursts     <= '0;
      gap            <= '0;
      gap_cnt        <= '0;
      beat           <= '0;
      empty_hold     <= 1'b0;
      gen.gen_ena    <= 1'b0;
      gen.gen_seed   <= '0;
      gen.gen_patcnt <= '0;
      gen.gen_wr_en  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      burst_idx      <= '0;
      word_cnt       <= '0;
      stall_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            word_cnt  <= '0;
            stall_cnt <= '0;
            burst_idx <= '0;
            aborted   <= 1'b0;
            busy      <= 1'b1;
            if (cfg_num_bursts != 8'd0) begin
              gen.gen_seed   <= cfg_seed;
              gen.gen_patcnt <= cfg_burst_len;
              num_bursts     <= cfg_num_bursts;
              gap            <= cfg_gap;
              gen.gen_ena    <= 1'b1;
              state          <= LOAD;
            end else begin
              // An empty run lingers one extra cycle in DONE so done lands two cycles after start.
              empty_hold <= 1'b1;
              state      <= DONE;
            end
          end
        end

        LOAD: begin
          gen.gen_ena <= 1'b0;
          beat        <= '0;
          if (abort) begin
            aborted <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            gen.gen_wr_en <= 1'b1;
            state         <= BURST;
          end
        end

        BURST: begin
          if (gen.gen_fifo_full) begin
            if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
          end else begin
            beat     <= beat + 8'd1;
            word_cnt <= word_cnt + 16'd1;
          end
          // Abort freezes seed and burst index even when it coincides with the last word.
          if (abort) begin
            aborted       <= 1'b1;
            done          <= 1'b1;
            gen.gen_wr_en <= 1'b0;
            state         <= DONE;
          end else if (last_word) begin
            gen.gen_wr_en <= 1'b0;
            gen.gen_seed  <= gen.gen_seed + SW'(gen.gen_patcnt) + SW'(1);
            if (burst_idx == num_bursts - 8'd1) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              burst_idx <= burst_idx + 8'd1;
              if (gap == 4'd0) begin
                gen.gen_ena <= 1'b1;
                state       <= LOAD;
              end else begin
                gap_cnt <= gap - 4'd1;
                state   <= GAP;
              end
            end
          end
        end

        GAP: begin
          if (abort) begin
            aborted <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else if (gap_cnt == 4'd0) begin
            gen.gen_ena <= 1'b1;
            state       <= LOAD;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end

        DONE: begin
          if (abort) aborted <= 1'b1;
          if (empty_hold) begin
            empty_hold <= 1'b0;
            done       <= 1'b1;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aximm_patgen_seq.md
# aximm_patgen_seq

Run sequencer for the AXI-MM incrementing pattern generator. It takes a run configuration, issues a series of bursts by pulsing the generator's enable with a fresh seed and word count for each burst, and paces bursts around checker-FIFO backpressure. It also inserts programmable idle gaps and reports run status and statistics. It sits between the test-control CSRs and the pattern generator/checker pair on both leader and follower sides.

## Interface
- LEADER_MODE, 1, seed/data width multiplier; SW = LEADER_MODE*40.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a run from IDLE.
- abort  in  1  pulse; terminates the run in progress.
- cfg_seed  in  SW  seed for the first burst.
- cfg_burst_len  in  8  words per burst minus one (0 → 1 word, 255 → 256 words).
- cfg_num_bursts  in  8  bursts per run; 0 means an empty run.
- cfg_gap  in  4  idle cycles between bursts.
- gen_fifo_full  in  1  checker FIFO full; no word is accepted that cycle.
- gen_ena  out  1  one-cycle seed-load/start pulse to the generator.
- gen_seed  out  SW  seed for the current burst.
- gen_patcnt  out  8  registered copy of cfg_burst_len.
- gen_wr_en  out  1  word valid; high throughout BURST.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at run end.
- aborted  out  1  sticky; set by abort, cleared on the next accepted start.
- burst_idx  out  8  index of the current burst, starting at 0.
- word_cnt  out  16  accepted words this run, wraps modulo 2^16.
- stall_cnt  out  16  BURST cycles with gen_fifo_full high; saturates at 0xFFFF.

## Operation
- States: IDLE, LOAD, BURST, GAP, DONE.
- IDLE
  - start with cfg_num_bursts≠0: latch cfg_* into shadow registers, clear word_cnt, stall_cnt, burst_idx and aborted, then go to LOAD.
  - start with cfg_num_bursts=0: clear the counters and go to DONE; no gen_ena is issued.
  - Changes to cfg_* after start have no effect until the next start.
- LOAD: gen_ena=1 and gen_seed=current seed; next state BURST. The beat counter resets to 0.
- BURST
  - gen_wr_en=1.
  - A word is accepted on each cycle with gen_fifo_full=0. An accepted word increments the beat counter and word_cnt.
  - A cycle with gen_fifo_full=1 holds the beat counter and increments stall_cnt.
  - The last word is accepted when beat==shadow burst_len. On that cycle: seed += burst_len+1 (modulo 2^SW), then take the first applicable exit:
    - burst_idx==num_bursts-1: go to DONE; burst_idx holds.
    - gap=0: burst_idx++ and go to LOAD.
    - otherwise: burst_idx++, load the gap counter, and go to GAP.
- GAP: the gap counter decrements each cycle; go to LOAD after cfg_gap cycles.
- DONE: done=1 for one cycle, then go to IDLE.
- abort
  - In LOAD, BURST or GAP: set aborted and go to DONE next cycle. The word on that cycle is still counted if accepted. Seed and burst_idx are frozen.
  - In DONE: aborted is set and the state still goes to IDLE.
  - In IDLE: ignored.
  - Simultaneous start and abort in IDLE: abort wins and no run starts.
- start while busy is ignored.
- Reset mid-run: all state returns to IDLE immediately and asynchronously; no done pulse is produced.

## Timing
- Reset values: all outputs 0, including gen_seed, gen_patcnt, aborted, and all counters. Internal state is IDLE.
- start at cycle T → gen_ena at T+1 → first gen_wr_en at T+2.
- With no backpressure and gap=0, a burst of N words occupies N BURST cycles plus 1 LOAD cycle. gen_ena for the next burst appears on the cycle after the last accepted word.
- With gap=G, there are G GAP cycles between the last accepted word and the next LOAD cycle.
- done asserts 1 cycle after the last accepted word, or 2 cycles after start for an empty run. busy falls in the same cycle that done falls.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Single burst: seed=0x10, len=3, bursts=1, gap=0, no full → gen_ena at T+1 with gen_seed=0x10. gen_wr_en is high for 4 cycles, done at T+6, word_cnt=4, stall_cnt=0.
- Multi-burst seed stepping: seed=0xFF_FFFF_FFFE, len=1, bursts=3, gap=2 → seeds 0xFF_FFFF_FFFE, 0x0, 0x2 (wrap). There are 2 GAP cycles before each of the 2nd and 3rd LOAD, and word_cnt=6.
- Backpressure: len=7, bursts=1, gen_fifo_full high for 5 scattered BURST cycles → BURST lasts 13 cycles, stall_cnt=5, word_cnt=8.
- Abort mid-burst: bursts=4, abort during the 2nd burst → DONE next cycle, aborted=1, burst_idx=1, no further gen_ena. A later start clears aborted.
- Corner configurations: bursts=0 → done at T+2 with no gen_ena. len=255 → 256 words per burst. start+abort together in IDLE → stays idle. start while busy → ignored.
- Reset: assert rst_n low mid-BURST → all outputs 0 immediately (asynchronous), no done pulse. After release, a fresh start runs normally.
